// File: rtl/conv2d_mac3x3_pipe_pkg.sv
// conv_pkg: shared constants, accumulation state type and saturation helper for conv2d_mac3x3_pipe
package conv_pkg;
  localparam int DW_DEF = 8;
  localparam int WW_DEF = 8;
  localparam int ACCW_DEF = 32;
  localparam int OW_DEF = 16;
  localparam int WIN_N = 9;
  typedef enum logic {IDLE, OPEN} acc_st_e;
  function automatic logic signed [63:0] sat(input logic signed [63:0] v, input int unsigned ow);
    logic signed [63:0] mx, mn;
    mx = (64'sd1 <<< (ow - 1)) - 64'sd1;
    mn = -mx - 64'sd1;
    return v > mx ? mx : v < mn ? mn : v;
  endfunction
endpackage

// File: rtl/conv2d_mac3x3_pipe_if.sv
// conv2d_mac3x3_pipe_if: beat-in / pixel-out handshake bundle for conv2d_mac3x3_pipe
interface conv2d_mac3x3_pipe_if
  import conv_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int WW = WW_DEF,
  parameter int ACCW = ACCW_DEF,
  parameter int OW = OW_DEF
);
  logic in_valid;
  logic in_ready;
  logic in_first;
  logic in_last;
  logic [WIN_N*DW-1:0] win;
  logic [WIN_N*WW-1:0] wgt;
  logic signed [ACCW-1:0] bias;
  logic out_valid;
  logic out_ready;
  logic signed [OW-1:0] result;
  logic err_seq;
  modport master (
    output in_valid, in_first, in_last, win, wgt, bias, out_ready,
    input in_ready, out_valid, result, err_seq
  );
  modport slave (
    input in_valid, in_first, in_last, win, wgt, bias, out_ready,
    output in_ready, out_valid, result, err_seq
  );
endinterface

// File: rtl/conv2d_mac3x3_pipe_sat.sv
// conv_sat_clip: ACCW-to-OW signed saturator, rectifying negatives first when CONV2D_RELU_EN is defined
module conv_sat_clip
  import conv_pkg::*;
#(
  parameter int ACCW = ACCW_DEF,
  parameter int OW = OW_DEF
) (
  input logic signed [ACCW-1:0] a,
  output logic signed [OW-1:0] y
);
  logic signed [ACCW-1:0] r;
`ifdef CONV2D_RELU_EN
  assign r = a[ACCW-1] ? '0 : a;
`else
  assign r = a;
`endif
  assign y = OW'(sat(64'(r), OW));
endmodule

// File: rtl/conv2d_mac3x3_pipe.sv
// conv2d_mac3x3_pipe: pipelined 3x3 multi-channel MAC with bias and saturation (optional ReLU via CONV2D_RELU_EN)
module conv2d_mac3x3_pipe
  import conv_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int WW = WW_DEF,
  parameter int ACCW = ACCW_DEF,
  parameter int OW = OW_DEF
) (
  input logic clk,
  input logic rst,
  conv2d_mac3x3_pipe_if.slave bus
);
  localparam int PW = DW + WW;
  localparam int RW = PW + 2;
  logic stall, acc_in, bad, eff_first;
  logic signed [ACCW-1:0] eff_bias;
  acc_st_e st;
  logic s1_v, s1_first, s1_last;
  logic signed [ACCW-1:0] s1_bias;
  logic signed [PW-1:0] s1_prod [WIN_N];
  logic s2_v, s2_first, s2_last;
  logic signed [ACCW-1:0] s2_bias;
  logic signed [RW-1:0] s2_row [3];
  logic signed [ACCW-1:0] acc, total, acc_next;
  logic signed [OW-1:0] sat_res;
  assign stall = bus.out_valid && !bus.out_ready;
  assign bus.in_ready = !stall && !rst;
  assign acc_in = bus.in_valid && bus.in_ready;
  // a missing first in IDLE or a repeated first in OPEN are both sequence errors
  assign bad = (st == IDLE) != bus.in_first;
  assign eff_first = bus.in_first || st == IDLE;
  assign eff_bias = (st == IDLE && !bus.in_first) ? '0 : bus.bias;
  assign total = ACCW'(s2_row[0]) + ACCW'(s2_row[1]) + ACCW'(s2_row[2]);
  assign acc_next = (s2_first ? s2_bias : acc) + total;
  conv_sat_clip #(.ACCW(ACCW), .OW(OW)) u_sat (.a(acc_next), .y(sat_res));
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= IDLE;
      bus.err_seq <= 1'b0;
      s1_v <= 1'b0;
      s1_first <= 1'b0;
      s1_last <= 1'b0;
      s1_bias <= '0;
      s2_v <= 1'b0;
      s2_first <= 1'b0;
      s2_last <= 1'b0;
      s2_bias <= '0;
      acc <= '0;
      bus.out_valid <= 1'b0;
      bus.result <= '0;
    end else if (!stall) begin
      s1_v <= acc_in;
      if (acc_in) begin
        st <= bus.in_last ? IDLE : OPEN;
        bus.err_seq <= bus.err_seq | bad;
        s1_first <= eff_first;
        s1_last <= bus.in_last;
        s1_bias <= eff_bias;
        for (int k = 0; k < WIN_N; k++)
          s1_prod[k] <= PW'($signed(bus.win[k*DW +: DW])) * PW'($signed(bus.wgt[k*WW +: WW]));
      end
      s2_v <= s1_v;
      s2_first <= s1_first;
      s2_last <= s1_last;
      s2_bias <= s1_bias;
      for (int r = 0; r < 3; r++)
        s2_row[r] <= RW'(s1_prod[3*r]) + RW'(s1_prod[3*r+1]) + RW'(s1_prod[3*r+2]);
      if (s2_v) acc <= acc_next;
      bus.out_valid <= s2_v && s2_last;
      if (s2_v && s2_last) bus.result <= sat_res;
    end
  end
endmodule

// File: doc/conv2d_mac3x3_pipe.md
Name: conv2d_mac3x3_pipe

Overview:
Parametrised, pipelined successor to the single-cycle DSP 3×3 convolution engine.
- Multiplies a signed 3×3 window by a signed 3×3 kernel per beat.
- Accumulates the result across multiple input channels; the channel groups are delimited by first/last tags.
- Adds a per-pixel bias and saturates to the output width.
- Sits between the line-buffer/window generator and the output feature-map writer.
- Uses valid/ready handshakes on both sides.

Parameters:
DW, 8, signed activation width
WW, 8, signed weight width
ACCW, 32, channel accumulator width (must be ≥ DW+WW+4)
OW, 16, signed output width (≤ ACCW)

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous active-high
in_valid  in  1  beat valid
in_ready  out  1  beat accepted when in_valid && in_ready
in_first  in  1  first channel beat of an output pixel
in_last  in  1  last channel beat of an output pixel
win  in  9*DW  window, element k at [k*DW +: DW], row-major
wgt  in  9*WW  kernel, same packing
bias  in  ACCW  signed bias, sampled on the accepted in_first beat
out_valid  out  1  result valid
out_ready  in  1  downstream accept
result  out  OW  signed saturated pixel result
err_seq  out  1  sticky protocol error

Behaviour:
- Reset (synchronous, active-high) behaviour:
  - Clears out_valid, result, err_seq, the accumulator and all stage valid/tag registers to 0.
  - Reset mid-operation discards all in-flight beats and any partial accumulation.
  - in_ready is 0 during reset.
- Stall control:
  - stall = out_valid && !out_ready.
  - in_ready = !stall && !rst.
  - While stall is high, all pipeline registers hold.
- Pipeline (beats advance one stage per unstalled cycle):
  - S1: nine signed products, each DW+WW bits, registered. first/last/bias travel with the beat.
  - S2: three row sums, each DW+WW+2 bits, registered.
  - S3: total = sign-extended sum of the row sums to ACCW. acc_next = (first ? bias : acc) + total, registered into acc.
  - Output: on an S3 beat with last=1, result <= sat(acc_next) and out_valid <= 1.
- Latency: accepted last beat → out_valid is 3 cycles with no stalls. Throughput is 1 beat/cycle.
- out_valid clears on the handshake unless a new last beat completes in the same cycle; in that case result updates and out_valid stays 1.
- Saturation: values > 2^(OW-1)-1 clamp to the max; values < -2^(OW-1) clamp to the min.
- The accumulator wraps modulo 2^ACCW; no overflow detection is required.
- Single-channel pixel: first=last=1 on the same beat, so result = bias + dot product.
- Accumulation state machine (tracked at input acceptance):
  - States: IDLE and OPEN.
  - IDLE + first && !last → OPEN.
  - OPEN + last → IDLE.
  - IDLE + first && last → IDLE.
  - IDLE + !first: sets err_seq. The beat is treated as first with bias 0.
  - OPEN + first: sets err_seq. The open accumulation is dropped and restarted.
- err_seq clears only on rst.

Optional Feature:
- Macro: CONV2D_RELU_EN.
- When defined: negative acc_next is replaced by 0 before saturation, so result ≥ 0.
- When undefined: signed saturation only.
- The accumulator itself is never rectified in either case.

Decomposition:
- Shared package conv_pkg holds:
  - default DW/WW/ACCW/OW constants
  - window size constant (9)
  - accumulation state typedef (IDLE/OPEN)
  - saturation function
- One natural sub-module, conv_sat_clip: parametrised ACCW→OW saturator, including the ReLU option.

Test Plan:
- Basic: reset 2 cycles. One beat with all win=1, all wgt=1, bias=0, first=last=1 → result=9 exactly 3 cycles after acceptance, out_valid 1 cycle with out_ready=1.
- Channels: 3 beats with first on beat 0 and last on beat 2, windows of all 1/2/3 ones, wgt=1, bias=5 → single result 5+9+18+27=59. No out_valid on beats 0–1.
- Backpressure: stream 4 single-channel pixels with out_ready held low 5 cycles → in_ready drops, no beat lost, results emerge in order with values unchanged.
- Saturation: win=127, wgt=127, bias=2^20 with OW=16 → result=32767. win=-128, wgt=127 → result=-32768. With CONV2D_RELU_EN, the second case gives 0.
- Protocol error: a beat with first=0 after reset → err_seq=1 and result = dot product with bias 0. A second first while OPEN → restart accumulation, err_seq stays 1.
- Reset mid-stream: assert rst during the second beat of a 3-channel pixel → no out_valid afterwards. A fresh single-beat pixel returns a correct result.
